w0rm_irq_arbiter: RTL

Collects NUM_IRQ peripheral interrupt lines, latches them as pending, and applies per-line masks and a global enable. A fixed-priority arbiter picks one line and presents it to the core interrupt unit as peripheral_interrupt plus an ISR vector number. The block then sequences the request/accept/return handshake with that unit, one ISR at a time. A small memory-mapped register port provides configuration and status.

---
 rtl/w0rm_irq_arbiter_pkg.sv | 21 ++
 rtl/w0rm_irq_arbiter_if.sv | 28 ++
 rtl/w0rm_irq_arbiter_priority_enc.sv | 21 ++
 rtl/w0rm_irq_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/w0rm_irq_arbiter_pkg.sv
// Shared definitions for the w0rm interrupt arbiter: register offsets,
// controller state encoding and vector numbering constants.
package w0rm_irq_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_SWSET   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    // Vector 0 belongs to the core's own interrupt, so peripheral line i uses i+1.
    localparam int unsigned VEC_RESERVED = 32'd0;
    localparam int unsigned VEC_OFFSET   = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/w0rm_irq_arbiter_if.sv
// Bundle of the core-interrupt handshake and the register port.
// The arbiter is the slave; the core / bus side is the master.
interface w0rm_irq_arbiter_if #(
    parameter int ISR_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  peripheral_interrupt;
    logic [ISR_WIDTH-1:0]  peripheral_isr_number;
    logic                  isr_addr_valid;
    logic                  isr_return;
    logic                  mem_valid;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_ready;

    modport master (
        input  peripheral_interrupt, peripheral_isr_number, mem_data_out, mem_ready,
        output isr_addr_valid, isr_return, mem_valid, mem_write, mem_addr, mem_data_in
    );

    modport slave (
        output peripheral_interrupt, peripheral_isr_number, mem_data_out, mem_ready,
        input  isr_addr_valid, isr_return, mem_valid, mem_write, mem_addr, mem_data_in
    );
endinterface

// File: rtl/w0rm_irq_arbiter_priority_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module w0rm_irq_priority_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 8
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);

    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            found_o = found_o | req_i[i];
            index_o = req_i[i] ? IDX_W'(i) : index_o;
        end
    end

endmodule

// File: rtl/w0rm_irq_arbiter.sv
// Peripheral interrupt arbiter: edge-latched pending lines, mask/enable,
// fixed-priority selection and a one-at-a-time request/accept/return handshake.
module w0rm_irq_arbiter
    import w0rm_irq_pkg::*;
#(
    parameter int NUM_IRQ    = 8,
    parameter int ISR_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    w0rm_irq_arbiter_if.slave  bus
);

    state_e                state_q, state_d;
    logic [NUM_IRQ-1:0]    pending_q, pending_d;
    logic [NUM_IRQ-1:0]    mask_q, mask_d;
    logic [NUM_IRQ-1:0]    irq_prev_q;
    logic                  enable_q, enable_d;
    logic                  req_q, req_d;
    logic [ISR_WIDTH-1:0]  isr_num_q, isr_num_d;
    logic [ISR_WIDTH-1:0]  win_idx_q, win_idx_d;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_IRQ-1:0]    eligible_s, edge_s, w1c_s, swset_s, accept_clr_s;
    logic                  found_s, accept_s, wr_s, rd_s;
    logic [ISR_WIDTH-1:0]  enc_idx_s;
    logic [2:0]            reg_off_s;
    logic                  unused_s;

    assign edge_s     = irq_in & ~irq_prev_q;
    assign eligible_s = enable_q ? (pending_q & mask_q) : '0;
    assign wr_s       = bus.mem_valid & bus.mem_write;
    assign rd_s       = bus.mem_valid & ~bus.mem_write;
    assign reg_off_s  = bus.mem_addr[4:2];
    assign unused_s   = ^{bus.mem_addr[ADDR_WIDTH-1:5], bus.mem_addr[1:0],
                          bus.mem_data_in[DATA_WIDTH-1:NUM_IRQ]};

    w0rm_irq_priority_enc #(.N(NUM_IRQ), .IDX_W(ISR_WIDTH)) u_enc (
        .req_i   (eligible_s),
        .found_o (found_s),
        .index_o (enc_idx_s)
    );

    // Handshake sequencer; the winner is frozen once the request is raised.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        isr_num_d = isr_num_q;
        win_idx_d = win_idx_q;
        accept_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    win_idx_d = enc_idx_s;
                    isr_num_d = enc_idx_s + ISR_WIDTH'(VEC_OFFSET);
                    req_d     = 1'b1;
                    state_d   = ST_REQUEST;
                end else begin
                    req_d = 1'b0;
                end
            end
            ST_REQUEST: begin
                if (bus.isr_addr_valid) begin
                    accept_s = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_SERVICE;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (bus.isr_return) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Register port decode: write effects and read data captured together.
    always_comb begin
        mask_d   = mask_q;
        enable_d = enable_q;
        w1c_s    = '0;
        swset_s  = '0;
        rdata_d  = '0;
        if (wr_s) begin
            case (reg_off_s)
                REG_CTRL:    enable_d = bus.mem_data_in[0];
                REG_MASK:    mask_d   = bus.mem_data_in[NUM_IRQ-1:0];
                REG_PENDING: w1c_s    = bus.mem_data_in[NUM_IRQ-1:0];
                REG_SWSET:   swset_s  = bus.mem_data_in[NUM_IRQ-1:0];
                default:     mask_d   = mask_q;
            endcase
        end else if (rd_s) begin
            case (reg_off_s)
                REG_CTRL:    rdata_d = DATA_WIDTH'(enable_q);
                REG_MASK:    rdata_d = DATA_WIDTH'(mask_q);
                REG_PENDING: rdata_d = DATA_WIDTH'(pending_q);
                REG_STATUS: begin
                    rdata_d[DATA_WIDTH-1]  = (state_q != ST_IDLE);
                    rdata_d[DATA_WIDTH-2]  = (state_q == ST_SERVICE);
                    rdata_d[ISR_WIDTH-1:0] = isr_num_q;
                end
                default:     rdata_d = '0;
            endcase
        end else begin
            rdata_d = '0;
        end
    end

    // Edge and software sets win over any clear landing on the same bit.
    assign accept_clr_s = accept_s ? (NUM_IRQ'(1) << win_idx_q) : '0;
    assign pending_d    = (pending_q & ~(w1c_s | accept_clr_s)) | edge_s | swset_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            irq_prev_q <= '0;
            enable_q   <= 1'b0;
            req_q      <= 1'b0;
            isr_num_q  <= ISR_WIDTH'(VEC_RESERVED);
            win_idx_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_prev_q <= irq_in;
            enable_q   <= enable_d;
            req_q      <= req_d;
            isr_num_q  <= isr_num_d;
            win_idx_q  <= win_idx_d;
            ready_q    <= bus.mem_valid;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.peripheral_interrupt  = req_q;
    assign bus.peripheral_isr_number = isr_num_q;
    assign bus.mem_ready             = ready_q;
    assign bus.mem_data_out          = rdata_q;

endmodule
